// File: rtl/fir_out_packer.sv
// fir_out_packer: packs LANES FIR output samples into one wide word
// with a byte-keep mask, end-of-frame flush and accepted-sample count.
module fir_out_packer #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_W-1:0]         din_rsc_dat,
  input  logic                      din_rsc_vld,
  output logic                      din_rsc_rdy,
  input  logic                      flush,
  output logic [DATA_W*LANES-1:0]   dout_dat,
  output logic [LANES-1:0]          dout_keep,
  output logic                      dout_vld,
  input  logic                      dout_rdy,
  output logic [CNT_W-1:0]          sample_cnt
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int WW = DATA_W * LANES;
  localparam logic [LW-1:0] LAST = LW'(LANES - 1);

  typedef enum logic {
    ACC,
    PEND
  } state_t;

  state_t            state, state_d;
  logic [LW-1:0]     lane, lane_d;
  logic [WW-1:0]     acc, acc_d, acc_w;
  logic [WW-1:0]     dat_d;
  logic [LANES-1:0]  keep_d, keep_m;
  logic              vld_d;
  logic              take, free, full;
  logic [LW:0]       fill;

  // Input handshake, accumulator write and filled-lane mask.
  always_comb begin
    free        = !dout_vld | dout_rdy;
    din_rsc_rdy = !rst && (state == ACC) && ((lane != LAST) || free);
    take        = din_rsc_vld & din_rsc_rdy;
    full        = take && (lane == LAST);
    fill        = {1'b0, lane} + {{LW{1'b0}}, take};
    acc_w       = acc;
    if (take)
      acc_w[lane*DATA_W +: DATA_W] = din_rsc_dat;
    keep_m = '0;
    for (int i = 0; i < LANES; i++)
      keep_m[i] = (i < int'(fill));
  end

  // Next state, lane, accumulator and output register contents.
  always_comb begin
    state_d = state;
    lane_d  = lane;
    acc_d   = acc;
    dat_d   = dout_dat;
    keep_d  = dout_keep;
    vld_d   = dout_vld & !dout_rdy;
    unique case (state)
      ACC: begin
        if (full) begin
          dat_d  = acc_w;
          keep_d = '1;
          vld_d  = 1'b1;
          lane_d = '0;
          acc_d  = '0;
        end else if (flush && (fill != '0)) begin
          if (free) begin
            dat_d  = acc_w;
            keep_d = keep_m;
            vld_d  = 1'b1;
            lane_d = '0;
            acc_d  = '0;
          end else begin
            state_d = PEND;
            acc_d   = acc_w;
            lane_d  = fill[LW-1:0];
          end
        end else if (take) begin
          acc_d  = acc_w;
          lane_d = lane + 1'b1;
        end
      end
      PEND: begin
        if (free) begin
          dat_d   = acc;
          keep_d  = keep_m;
          vld_d   = 1'b1;
          lane_d  = '0;
          acc_d   = '0;
          state_d = ACC;
        end
      end
      default: state_d = ACC;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACC;
    else     state <= state_d;
  end

  // Datapath registers and sample counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane       <= '0;
      acc        <= '0;
      dout_dat   <= '0;
      dout_keep  <= '0;
      dout_vld   <= 1'b0;
      sample_cnt <= '0;
    end else begin
      lane      <= lane_d;
      acc       <= acc_d;
      dout_dat  <= dat_d;
      dout_keep <= keep_d;
      dout_vld  <= vld_d;
      if (take)
        sample_cnt <= sample_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_out_packer.sv
// tb_fir_out_packer: directed vectors, expected words queued in a
// scoreboard and checked by an independent output monitor.
module tb_fir_out_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  din_rsc_dat = '0;
  logic        din_rsc_vld = 1'b0;
  logic        din_rsc_rdy;
  logic        flush = 1'b0;
  logic [31:0] dout_dat;
  logic [3:0]  dout_keep;
  logic        dout_vld;
  logic        dout_rdy = 1'b0;
  logic [15:0] sample_cnt;

  int total = 0;
  int bad   = 0;
  logic [35:0] sb[$];

  fir_out_packer #(.DATA_W(8), .LANES(4), .CNT_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .din_rsc_dat(din_rsc_dat),
    .din_rsc_vld(din_rsc_vld),
    .din_rsc_rdy(din_rsc_rdy),
    .flush(flush),
    .dout_dat(dout_dat),
    .dout_keep(dout_keep),
    .dout_vld(dout_vld),
    .dout_rdy(dout_rdy),
    .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [35:0] act,
                     input logic [35:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic expect_word(input logic [31:0] d, input logic [3:0] k);
    sb.push_back({d, k});
  endtask

  // Output monitor: every delivered word must match the queue head.
  always @(negedge clk) begin
    if (!rst && dout_vld && dout_rdy) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word: got %h/%h want none",
                 dout_dat, dout_keep);
      end else begin
        chk("word", {dout_dat, dout_keep}, sb.pop_front());
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic fl = 1'b0);
    int n;
    n = 0;
    din_rsc_dat = d;
    din_rsc_vld = 1'b1;
    flush = fl;
    do begin
      @(negedge clk);
      n++;
    end while (!din_rsc_rdy && n < 60);
    if (!din_rsc_rdy) begin
      chk("send_timeout", 36'(n), 36'(0));
      din_rsc_vld = 1'b0;
      flush = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    din_rsc_vld = 1'b0;
    flush = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    cycles(2);
    chk("rst_vld", 36'(dout_vld), 36'(0));
    chk("rst_keep", 36'(dout_keep), 36'(0));
    chk("rst_dat", 36'(dout_dat), 36'(0));
    chk("rst_cnt", 36'(sample_cnt), 36'(0));
    chk("rst_rdy", 36'(din_rsc_rdy), 36'(0));
    rst = 1'b0;
    dout_rdy = 1'b1;
    cycles(1);

    expect_word(32'h04030201, 4'hF);
    expect_word(32'h08070605, 4'hF);
    for (int i = 1; i <= 8; i++) begin
      send(8'(i));
      if (i == 4) begin
        chk("lat_vld", 36'(dout_vld), 36'(1));
        chk("lat_dat", 36'(dout_dat), 36'(32'h04030201));
      end
    end
    cycles(2);
    chk("cnt8", 36'(sample_cnt), 36'(8));

    dout_rdy = 1'b0;
    expect_word(32'h13121110, 4'hF);
    expect_word(32'h17161514, 4'hF);
    for (int i = 0; i < 7; i++)
      send(8'(8'h10 + i));
    chk("stall_rdy", 36'(din_rsc_rdy), 36'(0));
    chk("stall_hold", {dout_dat, dout_keep}, {32'h13121110, 4'hF});
    fork
      send(8'h17);
      begin
        cycles(3);
        chk("hold_late", 36'(dout_dat), 36'(32'h13121110));
        dout_rdy = 1'b1;
      end
    join
    cycles(3);

    expect_word(32'h00CCBBAA, 4'h7);
    send(8'hAA);
    send(8'hBB);
    send(8'hCC);
    pulse_flush();
    chk("part_keep", 36'(dout_keep), 36'(4'h7));

    expect_word(32'h44332211, 4'hF);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    send(8'h44, 1'b1);
    pulse_flush();
    cycles(2);
    chk("empty_flush", 36'(dout_vld), 36'(0));

    dout_rdy = 1'b0;
    expect_word(32'h54535251, 4'hF);
    expect_word(32'h00006261, 4'h3);
    for (int i = 1; i <= 4; i++)
      send(8'(8'h50 + i));
    send(8'h61);
    send(8'h62);
    pulse_flush();
    chk("pend_rdy", 36'(din_rsc_rdy), 36'(0));
    cycles(2);
    chk("pend_rdy2", 36'(din_rsc_rdy), 36'(0));
    chk("pend_hold", 36'(dout_dat), 36'(32'h54535251));
    dout_rdy = 1'b1;
    cycles(1);
    chk("pend_load", {dout_dat, dout_keep}, {32'h00006261, 4'h3});
    chk("pend_exit", 36'(din_rsc_rdy), 36'(1));
    cycles(2);

    dout_rdy = 1'b0;
    for (int i = 1; i <= 4; i++)
      send(8'(8'h70 + i));
    send(8'h81);
    send(8'h82);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_vld", 36'(dout_vld), 36'(0));
    chk("arst_keep", 36'(dout_keep), 36'(0));
    chk("arst_cnt", 36'(sample_cnt), 36'(0));
    chk("arst_rdy", 36'(din_rsc_rdy), 36'(0));
    cycles(2);
    rst = 1'b0;
    dout_rdy = 1'b1;
    expect_word(32'h94939291, 4'hF);
    for (int i = 1; i <= 4; i++)
      send(8'(8'h90 + i));
    cycles(3);
    chk("cnt_after_rst", 36'(sample_cnt), 36'(4));
    chk("sb_empty", 36'(sb.size()), 36'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
